// File: rtl/fc_psum_acc_pkg.sv
// Shared types and post-processing for FC output stages.
// Holds the psum accumulator FSM states and the sat/ReLU helper.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  localparam int PSUM_W  = 8;
  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  function automatic logic [PSUM_W-1:0] sat_relu(
    input int   a,
    input logic relu_en
  );
    logic [PSUM_W-1:0] r;
    if (relu_en && a < 0)
      r = '0;
    else if (a > OUT_MAX)
      r = 8'h7f;
    else if (a < OUT_MIN)
      r = 8'h80;
    else
      r = a[PSUM_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fc_psum_acc_if.sv
// Psum input stream and drained result stream of the FC accumulator.
// slave = accumulator side, master = PE column / output writer side.
interface fc_psum_acc_if;
  import fc_pkg::*;

  logic              psum_valid_i;
  logic [PSUM_W-1:0] psum_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [PSUM_W-1:0] out_data_o;

  modport slave (
    input  psum_valid_i,
    input  psum_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o
  );

  modport master (
    output psum_valid_i,
    output psum_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o
  );

endinterface

// File: rtl/fc_psum_acc.sv
// Multi-pass psum accumulator behind an FC systolic column.
// Accumulates per-index psums, then drains sat/ReLU results in order.
module fc_psum_acc
  import fc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ACC_W  = 16,
  parameter int PASS_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [$clog2(DEPTH+1)-1:0] len_i,
  input  logic [PASS_W-1:0]          passes_i,
  input  logic                       relu_en_i,
  fc_psum_acc_if.slave               bus,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t              state;
  logic [LEN_W-1:0]    len;
  logic [PASS_W-1:0]   passes;
  logic                relu;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    rd;
  logic [PASS_W-1:0]   pass;

  logic signed [ACC_W-1:0] acc [DEPTH];

  logic                    last_idx;
  logic                    last_pass;
  logic                    last_rd;
  logic                    acc_we;
  logic [LEN_W-1:0]        len_c;
  logic signed [ACC_W-1:0] psum_x;

  assign last_idx  = (LEN_W'(idx) == len - 1'b1);
  assign last_rd   = (LEN_W'(rd) == len - 1'b1);
  assign last_pass = (pass == passes - 1'b1);
  assign acc_we    = (state == ACCUM) && bus.psum_valid_i;

  assign len_c = (len_i > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_i;

  assign psum_x = {{(ACC_W-PSUM_W){bus.psum_i[PSUM_W-1]}},
                   bus.psum_i};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      len    <= '0;
      passes <= '0;
      relu   <= 1'b0;
      idx    <= '0;
      rd     <= '0;
      pass   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i && len_i != '0 && passes_i != '0) begin
            len    <= len_c;
            passes <= passes_i;
            relu   <= relu_en_i;
            idx    <= '0;
            pass   <= '0;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.psum_valid_i) begin
            if (last_idx) begin
              idx <= '0;
              if (last_pass) begin
                rd    <= '0;
                state <= DRAIN;
              end else begin
                pass <= pass + 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready_i) begin
            if (last_rd)
              state <= DONE;
            else
              rd <= rd + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // No reset on the buffer: pass 0 overwrites every live entry.
  always_ff @(posedge clk) begin
    if (acc_we)
      acc[idx] <= (pass == '0) ? psum_x : acc[idx] + psum_x;
  end

  assign bus.in_ready_o  = (state == ACCUM);
  assign bus.out_valid_o = (state == DRAIN);
  assign bus.out_data_o  = (state == DRAIN)
                         ? sat_relu(int'(acc[rd]), relu)
                         : '0;
  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

endmodule
